// File: rtl/cook_sequencer.sv
// Microwave cook controller.
// Keypad digits shift into an MM:SS BCD time register. The start key runs a
// one-second-per-tick countdown, and the controller then sounds a short done
// beep. The door interlock and the stop/clear key pause or abandon a cook.
module cook_sequencer #(
    parameter int QUICK_START_SEC = 30,
    parameter int BEEP_CYCLES     = 3
) (
    input  logic       clk_1s,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_open,
    output logic [3:0] first_sec_out,
    output logic [3:0] second_sec_out,
    output logic [3:0] first_min_out,
    output logic [3:0] second_min_out,
    output logic [2:0] state_out,
    output logic       magnetron_on,
    output logic       lamp_on,
    output logic       beep
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        COOKING = 3'd2,
        PAUSED  = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [3:0] QS_TENS   = 4'(QUICK_START_SEC / 10);
    localparam logic [3:0] QS_ONES   = 4'(QUICK_START_SEC % 10);
    localparam logic [3:0] BEEP_LOAD = 4'(BEEP_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic [3:0] sec_ones_next, sec_tens_next, min_ones_next, min_tens_next;
    logic [3:0] dec_sec_ones, dec_sec_tens, dec_min_ones, dec_min_tens;
    logic [3:0] beep_cnt, beep_cnt_next;
    logic       beep_next;
    logic       dec_zero;
    logic       time_zero;
    logic       key_ok;
    logic       start_ok;

    assign key_ok    = key_valid && (key_digit <= 4'd9);
    assign start_ok  = start && !door_open;
    assign time_zero = (sec_ones == 4'd0) && (sec_tens == 4'd0) &&
                       (min_ones == 4'd0) && (min_tens == 4'd0);
    assign dec_zero  = (dec_sec_ones == 4'd0) && (dec_sec_tens == 4'd0) &&
                       (dec_min_ones == 4'd0) && (dec_min_tens == 4'd0);

    // BCD one-second decrement of the current time; seconds 60..99 simply count down
    always_comb begin
        dec_sec_ones = sec_ones;
        dec_sec_tens = sec_tens;
        dec_min_ones = min_ones;
        dec_min_tens = min_tens;
        if (sec_ones != 4'd0) begin
            dec_sec_ones = sec_ones - 4'd1;
        end else if (sec_tens != 4'd0) begin
            dec_sec_ones = 4'd9;
            dec_sec_tens = sec_tens - 4'd1;
        end else begin
            dec_sec_ones = 4'd9;
            dec_sec_tens = 4'd5;
            if (min_ones != 4'd0) begin
                dec_min_ones = min_ones - 4'd1;
            end else begin
                dec_min_ones = 4'd9;
                dec_min_tens = min_tens - 4'd1;
            end
        end
    end

    // Next state, time and beep counter, with priority stop_clear > door > start > key
    always_comb begin
        state_next    = state;
        sec_ones_next = sec_ones;
        sec_tens_next = sec_tens;
        min_ones_next = min_ones;
        min_tens_next = min_tens;
        beep_next     = beep;
        beep_cnt_next = beep_cnt;
        case (state)
            IDLE, ENTRY: begin
                if (stop_clear) begin
                    state_next    = IDLE;
                    sec_ones_next = 4'd0;
                    sec_tens_next = 4'd0;
                    min_ones_next = 4'd0;
                    min_tens_next = 4'd0;
                end else if (start_ok) begin
                    state_next = COOKING;
                    if (time_zero) begin
                        sec_ones_next = QS_ONES;
                        sec_tens_next = QS_TENS;
                    end
                end else if (key_ok) begin
                    state_next    = ENTRY;
                    min_tens_next = min_ones;
                    min_ones_next = sec_tens;
                    sec_tens_next = sec_ones;
                    sec_ones_next = key_digit;
                end
            end
            COOKING: begin
                if (stop_clear || door_open) begin
                    state_next = PAUSED;
                end else begin
                    sec_ones_next = dec_sec_ones;
                    sec_tens_next = dec_sec_tens;
                    min_ones_next = dec_min_ones;
                    min_tens_next = dec_min_tens;
                    if (dec_zero) begin
                        state_next    = DONE;
                        beep_next     = 1'b1;
                        beep_cnt_next = BEEP_LOAD;
                    end
                end
            end
            PAUSED: begin
                if (stop_clear) begin
                    state_next    = IDLE;
                    sec_ones_next = 4'd0;
                    sec_tens_next = 4'd0;
                    min_ones_next = 4'd0;
                    min_tens_next = 4'd0;
                end else if (start_ok) begin
                    state_next = COOKING;
                end
            end
            DONE: begin
                if (stop_clear || (beep_cnt == 4'd0)) begin
                    state_next    = IDLE;
                    beep_next     = 1'b0;
                    beep_cnt_next = 4'd0;
                end else begin
                    beep_cnt_next = beep_cnt - 4'd1;
                end
            end
            default: begin
                state_next    = IDLE;
                beep_next     = 1'b0;
                beep_cnt_next = 4'd0;
            end
        endcase
    end

    // Register state, time, beeper and the outputs derived from the next state
    always_ff @(posedge clk_1s) begin
        if (reset) begin
            state        <= IDLE;
            sec_ones     <= 4'd0;
            sec_tens     <= 4'd0;
            min_ones     <= 4'd0;
            min_tens     <= 4'd0;
            beep         <= 1'b0;
            beep_cnt     <= 4'd0;
            magnetron_on <= 1'b0;
            lamp_on      <= 1'b0;
        end else begin
            state        <= state_next;
            sec_ones     <= sec_ones_next;
            sec_tens     <= sec_tens_next;
            min_ones     <= min_ones_next;
            min_tens     <= min_tens_next;
            beep         <= beep_next;
            beep_cnt     <= beep_cnt_next;
            magnetron_on <= (state_next == COOKING);
            lamp_on      <= door_open || (state_next == COOKING);
        end
    end

    assign first_sec_out  = sec_ones;
    assign second_sec_out = sec_tens;
    assign first_min_out  = min_ones;
    assign second_min_out = min_tens;
    assign state_out      = state;

endmodule

// File: tb/tb_cook_sequencer.sv
// Testbench for cook_sequencer.
// The reference model treats the time as one four-digit decimal number and a
// state number. It checks every output after every clock edge. Literal checks
// pin down the walkthrough scenarios.
module tb_cook_sequencer;

    localparam int QS = 30;
    localparam int BC = 3;
    localparam int S_IDLE = 0, S_ENTRY = 1, S_COOK = 2, S_PAUSE = 3, S_DONE = 4;

    logic       clk_1s = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       stop_clear = 1'b0;
    logic       door_open = 1'b0;
    logic [3:0] first_sec_out, second_sec_out, first_min_out, second_min_out;
    logic [2:0] state_out;
    logic       magnetron_on, lamp_on, beep;

    int checks = 0;
    int errors = 0;

    int mVal = 0;
    int mState = S_IDLE;
    int mBeepRem = 0;
    int mLamp = 0;

    cook_sequencer #(.QUICK_START_SEC(QS), .BEEP_CYCLES(BC)) dut (
        .clk_1s(clk_1s),
        .reset(reset),
        .key_valid(key_valid),
        .key_digit(key_digit),
        .start(start),
        .stop_clear(stop_clear),
        .door_open(door_open),
        .first_sec_out(first_sec_out),
        .second_sec_out(second_sec_out),
        .first_min_out(first_min_out),
        .second_min_out(second_min_out),
        .state_out(state_out),
        .magnetron_on(magnetron_on),
        .lamp_on(lamp_on),
        .beep(beep)
    );

    always #5 clk_1s = ~clk_1s;

    task automatic checkOne(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs that edge sampled
    task automatic modelStep();
        int m, s;
        if (reset) begin
            mVal = 0;
            mState = S_IDLE;
            mBeepRem = 0;
            mLamp = 0;
            return;
        end
        case (mState)
            S_IDLE, S_ENTRY: begin
                if (stop_clear) begin
                    mVal = 0;
                    mState = S_IDLE;
                end else if (start && !door_open) begin
                    if (mVal == 0) mVal = QS;
                    mState = S_COOK;
                end else if (key_valid && key_digit <= 9) begin
                    mVal = (mVal * 10 + int'(key_digit)) % 10000;
                    mState = S_ENTRY;
                end
            end
            S_COOK: begin
                if (stop_clear || door_open) begin
                    mState = S_PAUSE;
                end else begin
                    m = mVal / 100;
                    s = mVal % 100;
                    if (s > 0) s--;
                    else begin
                        s = 59;
                        m--;
                    end
                    mVal = m * 100 + s;
                    if (mVal == 0) begin
                        mState = S_DONE;
                        mBeepRem = BC;
                    end
                end
            end
            S_PAUSE: begin
                if (stop_clear) begin
                    mVal = 0;
                    mState = S_IDLE;
                end else if (start && !door_open) begin
                    mState = S_COOK;
                end
            end
            default: begin
                if (stop_clear) begin
                    mBeepRem = 0;
                    mState = S_IDLE;
                end else begin
                    mBeepRem--;
                    if (mBeepRem == 0) mState = S_IDLE;
                end
            end
        endcase
        mLamp = (door_open || mState == S_COOK) ? 1 : 0;
    endtask

    task automatic checkOutput();
        checkOne("sec_ones", int'(first_sec_out), mVal % 10);
        checkOne("sec_tens", int'(second_sec_out), (mVal / 10) % 10);
        checkOne("min_ones", int'(first_min_out), (mVal / 100) % 10);
        checkOne("min_tens", int'(second_min_out), mVal / 1000);
        checkOne("state", int'(state_out), mState);
        checkOne("magnetron", int'(magnetron_on), (mState == S_COOK) ? 1 : 0);
        checkOne("lamp", int'(lamp_on), mLamp);
        checkOne("beep", int'(beep), (mState == S_DONE) ? 1 : 0);
    endtask

    task automatic applyStimulus(input logic r, input logic kv, input logic [3:0] kd,
                                 input logic st, input logic sc, input logic door);
        reset = r;
        key_valid = kv;
        key_digit = kd;
        start = st;
        stop_clear = sc;
        door_open = door;
        @(posedge clk_1s);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic key(input logic [3:0] d);
        applyStimulus(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pressStart();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic pressClear();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic checkLit(input string name, input int mt, input int mo, input int st,
                            input int so, input int state);
        checkOne({name, ".min_tens"}, int'(second_min_out), mt);
        checkOne({name, ".min_ones"}, int'(first_min_out), mo);
        checkOne({name, ".sec_tens"}, int'(second_sec_out), st);
        checkOne({name, ".sec_ones"}, int'(first_sec_out), so);
        checkOne({name, ".state"}, int'(state_out), state);
    endtask

    initial begin
        @(negedge clk_1s);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checkLit("reset", 0, 0, 0, 0, 0);
        checkOne("reset.lamp", int'(lamp_on), 0);
        checkOne("reset.beep", int'(beep), 0);

        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        checkLit("entry5", 2, 3, 4, 5, 1);
        pressClear();
        checkLit("clear", 0, 0, 0, 0, 0);

        key(4'd0); key(4'd0); key(4'd0); key(4'd3);
        pressStart();
        checkLit("cook3", 0, 0, 0, 3, 2);
        checkOne("cook3.mag", int'(magnetron_on), 1);
        idle();
        checkLit("cook2", 0, 0, 0, 2, 2);
        idle();
        idle();
        checkLit("done", 0, 0, 0, 0, 4);
        checkOne("done.mag", int'(magnetron_on), 0);
        checkOne("done.beep", int'(beep), 1);
        idle();
        idle();
        checkOne("beep3", int'(beep), 1);
        idle();
        checkLit("after_beep", 0, 0, 0, 0, 0);
        checkOne("after_beep.beep", int'(beep), 0);

        key(4'd0); key(4'd1); key(4'd0); key(4'd0);
        pressStart();
        idle();
        checkLit("borrow_min", 0, 0, 5, 9, 2);
        pressClear();
        pressClear();

        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        pressStart();
        idle();
        checkLit("borrow_tens", 0, 9, 5, 9, 2);
        pressClear();
        pressClear();

        key(4'd0); key(4'd0); key(4'd7); key(4'd5);
        pressStart();
        idle();
        checkLit("sec74", 0, 0, 7, 4, 2);
        idle();
        checkLit("sec73", 0, 0, 7, 3, 2);
        pressClear();
        pressClear();

        pressStart();
        checkLit("quick", 0, 0, 3, 0, 2);
        pressClear();
        pressClear();

        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        checkLit("door_start", 0, 0, 0, 0, 0);
        checkOne("door_start.lamp", int'(lamp_on), 1);

        key(4'd0); key(4'd0); key(4'd1); key(4'd0);
        pressStart();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        checkLit("paused", 0, 0, 1, 0, 3);
        checkOne("paused.lamp", int'(lamp_on), 1);
        checkOne("paused.mag", int'(magnetron_on), 0);
        pressStart();
        idle();
        checkLit("resumed", 0, 0, 0, 9, 2);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        pressClear();
        checkLit("pause_clear", 0, 0, 0, 0, 0);

        key(4'd1); key(4'd2);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        checkLit("start_and_clear", 0, 0, 0, 0, 0);

        key(4'd5);
        pressStart();
        idle();
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        checkLit("mid_reset", 0, 0, 0, 0, 0);
        checkOne("mid_reset.mag", int'(magnetron_on), 0);

        key(4'hA);
        checkLit("key_a", 0, 0, 0, 0, 0);

        for (int i = 0; i < 4000; i++) begin
            applyStimulus(($urandom_range(0, 299) == 0),
                          ($urandom_range(0, 1) == 0),
                          4'($urandom_range(0, 15)),
                          ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 14) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
